// File: rtl/mem_pin_bridge.sv
// Load/store responder that serializes each core access over an 8-bit pin port
// with a 4-phase req/ack handshake. Optional ack timeout: MEM_PIN_BRIDGE_TIMEOUT_EN.
module mem_pin_bridge #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [2:0]  option,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        memory_response,
    output logic [7:0]  ext_dout,
    output logic        ext_oe,
    input  logic [7:0]  ext_din,
    output logic        ext_req,
    input  logic        ext_ack,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_REL,
        S_RESP
    } state_t;

    typedef struct packed {
        logic        wr;
        logic [2:0]  opt;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xfer_t;

    state_t                 state_q, state_d;
    xfer_t                  xfer, cap;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [3:0]             byte_idx, next_idx, last_idx;
    logic [31:0]            rd_shift;
    logic                   wait_miss, abort;

    function automatic logic [3:0] nbytes(input logic [1:0] sz);
        logic [3:0] n;
        case (sz)
            2'b00:   n = 4'd1;
            2'b01:   n = 4'd2;
            default: n = 4'd4;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] size_code(input logic [1:0] sz);
        logic [1:0] c;
        case (sz)
            2'b00:   c = 2'b00;
            2'b01:   c = 2'b01;
            default: c = 2'b10;
        endcase
        return c;
    endfunction

    // Frame layout by byte index: 0 header, 1-4 address LSB first, 5.. data LSB first.
    function automatic logic [7:0] byte_at(input xfer_t x, input logic [3:0] idx);
        logic [7:0] b;
        case (idx)
            4'd0:    b = {x.wr, size_code(x.opt[1:0]), 5'b0};
            4'd1:    b = x.addr[7:0];
            4'd2:    b = x.addr[15:8];
            4'd3:    b = x.addr[23:16];
            4'd4:    b = x.addr[31:24];
            4'd5:    b = x.wr ? x.wdata[7:0]   : 8'h00;
            4'd6:    b = x.wr ? x.wdata[15:8]  : 8'h00;
            4'd7:    b = x.wr ? x.wdata[23:16] : 8'h00;
            4'd8:    b = x.wr ? x.wdata[31:24] : 8'h00;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    function automatic logic oe_at(input xfer_t x, input logic [3:0] idx);
        return x.wr || (idx < 4'd5);
    endfunction

    // Read bytes enter at the top, so a short load ends up in the upper bytes.
    function automatic logic [31:0] load_result(input logic [2:0] opt, input logic [31:0] sh);
        logic [31:0] r;
        case (opt[1:0])
            2'b00:   r = opt[2] ? {24'h0, sh[31:24]} : {{24{sh[31]}}, sh[31:24]};
            2'b01:   r = opt[2] ? {16'h0, sh[31:16]} : {{16{sh[31]}}, sh[31:16]};
            default: r = sh;
        endcase
        return r;
    endfunction

    always_comb begin
        cap.wr    = memory_write;
        cap.opt   = option;
        cap.addr  = address;
        cap.wdata = write_data;
    end

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign next_idx  = byte_idx + 4'd1;
    assign last_idx  = 4'd4 + nbytes(xfer.opt[1:0]);
    assign wait_miss = ((state_q == S_REQ) && !ack_s) || ((state_q == S_REL) && ack_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ack_sync <= '0;
        else        ack_sync <= {ack_sync[SYNC_STAGES-2:0], ext_ack};
    end

`ifdef MEM_PIN_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    // Reloaded on entry to each ack-wait phase; abort once it runs out while still waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state_d != state_q) && ((state_d == S_REQ) || (state_d == S_REL))) begin
            tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
        end else if (wait_miss && (tmo_cnt != '0)) begin
            tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

    assign abort = wait_miss && (tmo_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err | abort;
    end
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        ext_req         = 1'b0;
        memory_response = 1'b0;
        case (state_q)
            S_IDLE:  if (memory_read || memory_write) state_d = S_SETUP;
            S_SETUP: state_d = S_REQ;
            S_REQ: begin
                ext_req = 1'b1;
                if (ack_s)      state_d = S_REL;
                else if (abort) state_d = S_RESP;
            end
            S_REL: begin
                if (!ack_s)     state_d = (byte_idx == last_idx) ? S_RESP : S_SETUP;
                else if (abort) state_d = S_RESP;
            end
            S_RESP: begin
                memory_response = 1'b1;
                state_d         = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pin byte and direction only change while ext_req is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer      <= '0;
            byte_idx  <= 4'd0;
            rd_shift  <= 32'h0;
            read_data <= 32'h0;
            ext_dout  <= 8'h00;
            ext_oe    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_SETUP) begin
                        xfer     <= cap;
                        byte_idx <= 4'd0;
                        rd_shift <= 32'h0;
                        ext_dout <= byte_at(cap, 4'd0);
                        ext_oe   <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (ack_s && !xfer.wr && (byte_idx > 4'd4))
                        rd_shift <= {ext_din, rd_shift[31:8]};
                end
                S_REL: begin
                    if (state_d == S_SETUP) begin
                        byte_idx <= next_idx;
                        ext_dout <= byte_at(xfer, next_idx);
                        ext_oe   <= oe_at(xfer, next_idx);
                    end
                end
                S_RESP: begin
                    ext_dout <= 8'h00;
                    ext_oe   <= 1'b0;
                end
                default: ;
            endcase
            if ((state_d == S_RESP) && !xfer.wr)
                read_data <= abort ? 32'h0 : load_result(xfer.opt, rd_shift);
        end
    end

endmodule

// File: tb/tb_mem_pin_bridge.sv
// Randomized bench: stimulus queues expected pin bytes and responses; a pin
// responder and a response monitor check them against a spec-level model.
module tb_mem_pin_bridge;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memory_read = 1'b0, memory_write = 1'b0;
    logic [2:0]  option = 3'b0;
    logic [31:0] address = 32'h0, write_data = 32'h0;
    logic [31:0] read_data;
    logic        memory_response;
    logic [7:0]  ext_dout;
    logic        ext_oe;
    logic [7:0]  ext_din;
    logic        ext_req;
    logic        ext_ack;
    logic        err;

    mem_pin_bridge #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .memory_read(memory_read), .memory_write(memory_write),
        .option(option), .address(address), .write_data(write_data),
        .read_data(read_data), .memory_response(memory_response),
        .ext_dout(ext_dout), .ext_oe(ext_oe), .ext_din(ext_din),
        .ext_req(ext_req), .ext_ack(ext_ack), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] dout; logic oe;} pbyte_t;
    typedef struct {logic [31:0] data; logic err;} resp_t;

    pbyte_t      exp_bytes[$];
    logic [7:0]  din_q[$];
    resp_t       exp_resp[$];
    logic [31:0] model_rd = 32'h0;
    logic        model_err = 1'b0;
    int          n_cmp = 0, n_fail = 0;
    int          ack_dly = 1;
    bit          no_ack = 1'b0;
    bit          resp_busy = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Load result from the memory word as the spec states it: size, then extension.
    function automatic logic [31:0] model_load(input logic [2:0] opt, input logic [31:0] mem);
        int unsigned v;
        if (opt[1:0] == 2'b00) begin
            v = mem & 32'hFF;
            if (!opt[2] && v >= 128) v = v - 256;
        end else if (opt[1:0] == 2'b01) begin
            v = mem & 32'hFFFF;
            if (!opt[2] && v >= 32768) v = v - 65536;
        end else begin
            v = mem;
        end
        return 32'(v);
    endfunction

    task automatic send(input bit rd, input bit wr, input logic [2:0] opt, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] mem, input bit aborted);
        int n;
        logic [1:0] sc;
        pbyte_t pb;
        n  = (opt[1:0] == 2'b00) ? 1 : (opt[1:0] == 2'b01) ? 2 : 4;
        sc = (n == 1) ? 2'b00 : (n == 2) ? 2'b01 : 2'b10;
        pb.dout = {wr, sc, 5'b0};
        pb.oe   = 1'b1;
        exp_bytes.push_back(pb);
        if (aborted) begin
            model_err = 1'b1;
            if (!wr) model_rd = 32'h0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                pb.dout = addr[8*i +: 8];
                exp_bytes.push_back(pb);
            end
            for (int i = 0; i < n; i++) begin
                pb.dout = wr ? wd[8*i +: 8] : 8'h00;
                pb.oe   = wr;
                exp_bytes.push_back(pb);
                if (!wr) din_q.push_back(mem[8*i +: 8]);
            end
            if (!wr) model_rd = model_load(opt, mem);
        end
        exp_resp.push_back('{model_rd, model_err});
        @(negedge clk);
        memory_read = rd; memory_write = wr; option = opt; address = addr; write_data = wd;
        @(negedge clk);
        option = 3'($urandom); address = $urandom; write_data = $urandom;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!memory_response && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        if (!memory_response) check("response_timeout", 32'd0, 32'd1);
        memory_read = 1'b0; memory_write = 1'b0;
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [2:0] opt, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] mem);
        int cyc;
        send(rd, wr, opt, addr, wd, mem, 1'b0);
        wait_resp(cyc);
    endtask

    // Pin-side responder: checks each presented byte and holds it stable under req.
    initial begin
        logic [7:0] held_dout;
        logic       held_oe;
        pbyte_t     pb;
        ext_ack = 1'b0;
        ext_din = 8'h00;
        forever begin
            @(negedge clk);
            if (rst_n && ext_req) begin
                resp_busy = 1'b1;
                held_dout = ext_dout;
                held_oe   = ext_oe;
                if (exp_bytes.size() == 0) begin
                    check("extra_byte", {24'h0, ext_dout}, 32'hFFFFFFFF);
                end else begin
                    pb = exp_bytes.pop_front();
                    check("byte_oe", {31'h0, ext_oe}, {31'h0, pb.oe});
                    if (pb.oe) check("byte_dout", {24'h0, ext_dout}, {24'h0, pb.dout});
                    else if (din_q.size() > 0) ext_din = din_q.pop_front();
                end
                if (!no_ack) begin
                    for (int i = 0; i < ack_dly; i++) begin
                        @(negedge clk);
                        if (ext_req) check("dout_stable", {23'h0, ext_oe, ext_dout}, {23'h0, held_oe, held_dout});
                    end
                    ext_ack = 1'b1;
                end
                while (ext_req) begin
                    @(negedge clk);
                    if (ext_req) check("dout_stable", {23'h0, ext_oe, ext_dout}, {23'h0, held_oe, held_dout});
                end
                for (int i = 0; i < ack_dly; i++) @(negedge clk);
                ext_ack   = 1'b0;
                resp_busy = 1'b0;
            end
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (rst_n && memory_response) begin
            if (exp_resp.size() == 0) begin
                check("unexpected_response", 32'd1, 32'd0);
            end else begin
                resp_t r;
                r = exp_resp.pop_front();
                check("read_data", read_data, r.data);
                check("err", {31'h0, err}, {31'h0, r.err});
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit, got %0d responses pending", exp_resp.size());
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_read_data", read_data, 32'h0);
        check("rst_outputs", {28'h0, memory_response, ext_oe, ext_req, err}, 32'h0);
        check("rst_dout", {24'h0, ext_dout}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases: SW, LB, LBU, LH, read+write collision.
        txn(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h1234_5678, 32'h0);
        txn(1'b1, 1'b0, 3'b000, 32'h0000_0003, 32'h0, 32'h0000_0080);
        txn(1'b1, 1'b0, 3'b100, 32'h0000_0003, 32'h0, 32'h0000_0080);
        txn(1'b1, 1'b0, 3'b001, 32'h0000_0010, 32'h0, 32'h0000_9234);
        txn(1'b1, 1'b1, 3'b000, 32'h0000_0020, 32'h0000_00AA, 32'h0);

        for (int t = 0; t < 40; t++) begin
            int kind;
            ack_dly = $urandom_range(0, 3);
            kind    = $urandom_range(0, 2);
            txn(kind != 1, kind != 0, 3'($urandom), $urandom, $urandom, $urandom);
        end

        // Reset in the middle of the address phase of a slow write.
        ack_dly = 20;
        send(1'b0, 1'b1, 3'b010, 32'hCAFE_0004, 32'hDEAD_BEEF, 32'h0, 1'b0);
        cyc = 0;
        while (exp_bytes.size() > 6 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_bytes.size() > 6) check("reach_addr_phase", 32'd0, 32'd1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        memory_write = 1'b0;
        #1;
        check("midrst_req_oe", {30'h0, ext_req, ext_oe}, 32'h0);
        check("midrst_dout", {24'h0, ext_dout}, 32'h0);
        check("midrst_read_data", read_data, 32'h0);
        check("midrst_resp_err", {30'h0, memory_response, err}, 32'h0);
        repeat (3) @(negedge clk);
        check("midrst_no_resp", {31'h0, memory_response}, 32'h0);
        rst_n = 1'b1;
        exp_bytes.delete();
        din_q.delete();
        exp_resp.delete();
        model_rd = 32'h0;
        cyc = 0;
        while ((resp_busy || ext_ack) && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        check("responder_idle", {31'h0, resp_busy}, 32'h0);
        repeat (4) @(negedge clk);
        ack_dly = 1;
        txn(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h8765_4321);
        for (int t = 0; t < 6; t++) begin
            ack_dly = $urandom_range(0, 3);
            txn(1'b1, 1'b0, 3'($urandom), $urandom, 32'h0, $urandom);
        end

`ifdef MEM_PIN_BRIDGE_TIMEOUT_EN
        // No ack at all on a word load: abort with err and a zero result.
        no_ack = 1'b1;
        send(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h0, 1'b1);
        wait_resp(cyc);
        check("timeout_latency_ok", {31'h0, cyc <= TMO + 8}, 32'd1);
        cyc = 0;
        while (resp_busy && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        no_ack = 1'b0;
        repeat (4) @(negedge clk);
        txn(1'b1, 1'b0, 3'b001, 32'h0000_0300, 32'h0, 32'h0000_1357);
`endif

        repeat (5) @(negedge clk);
        check("queues_drained", exp_bytes.size() + exp_resp.size() + din_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
